// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_REQ writeback sources.
// Define RF_WB_FWD_EN to add the two-port bypass of the pending (uncommitted) write.
module rf_wb_arbiter #(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_waddr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          rf_wen,
    output logic [ADDR_WIDTH-1:0]         rf_waddr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
`ifdef RF_WB_FWD_EN
    input  logic [ADDR_WIDTH-1:0]         fwd_raddr1,
    input  logic [ADDR_WIDTH-1:0]         fwd_raddr2,
    input  logic [DATA_WIDTH-1:0]         rf_rdata1,
    input  logic [DATA_WIDTH-1:0]         rf_rdata2,
    output logic [DATA_WIDTH-1:0]         fwd_rdata1,
    output logic [DATA_WIDTH-1:0]         fwd_rdata2,
`endif
    output logic                          busy
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]      ptr_q, ptr_d, gidx;
    logic [N_REQ-1:0]      gnt;
    logic                  found, xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // Rotating priority scan starting at ptr; wrap by compare so non-power-of-two N_REQ works.
    always_comb begin
        int idx;
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                gidx     = PTR_W'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

    assign req_ready = rst ? '0 : gnt;
    assign xfer      = found && !rst;
    assign busy      = |req_valid;
    assign sel_addr  = req_waddr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data  = req_wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        ptr_d   = ptr_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (xfer) begin
            ptr_d = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            // r0 writes are consumed here and never reach the register file.
            if (sel_addr != '0) begin
                wen_d   = 1'b1;
                waddr_d = sel_addr;
                wdata_d = sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rf_wen   = wen_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;

`ifdef RF_WB_FWD_EN
    assign fwd_rdata1 = (wen_q && waddr_q == fwd_raddr1 && fwd_raddr1 != '0) ? wdata_q : rf_rdata1;
    assign fwd_rdata2 = (wen_q && waddr_q == fwd_raddr2 && fwd_raddr2 != '0) ? wdata_q : rf_rdata2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed + randomized bench for rf_wb_arbiter against a queue-free behavioural model.
module tb_rf_wb_arbiter;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_waddr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            busy;
`ifdef RF_WB_FWD_EN
    logic [AW-1:0]   fwd_raddr1 = '0, fwd_raddr2 = '0;
    logic [DW-1:0]   rf_rdata1 = '0, rf_rdata2 = '0;
    logic [DW-1:0]   fwd_rdata1, fwd_rdata2;
`endif

    rf_wb_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_waddr(req_waddr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef RF_WB_FWD_EN
        .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_rdata1(fwd_rdata1), .fwd_rdata2(fwd_rdata2),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file as the environment sees it; it ignores the port while held in reset.
    logic [DW-1:0] tb_rf [32] = '{default: '0};
    always @(posedge clk) if (!rst && rf_wen) tb_rf[rf_waddr] <= rf_wdata;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int            mptr = 0;
    logic          mwen = 1'b0;
    logic [AW-1:0] mwaddr = '0;
    logic [DW-1:0] mwdata = '0;
    logic          mknown = 1'b0;
    logic [DW-1:0] mrf [32] = '{default: '0};
    int            last_g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check grant mid-cycle, check registered output after posedge.
    task automatic cyc(input logic r, input logic [N-1:0] v,
                       input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        int g;
        logic [N-1:0] exp_rdy;
        logic [AW-1:0] ga;
        @(negedge clk);
        rst = r; req_valid = v; req_waddr = a; req_wdata = d;
        #1;
        g = -1;
        if (!r)
            for (int k = 0; k < N; k++)
                if (g < 0 && v[(mptr + k) % N]) g = (mptr + k) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(|v));
        @(posedge clk);
        if (!r && mwen) mrf[mwaddr] = mwdata;
        if (r) begin
            mptr = 0; mwen = 1'b0; mwaddr = '0; mwdata = '0; mknown = 1'b1;
        end else if (g >= 0) begin
            mptr = (g + 1) % N;
            ga   = a[g*AW +: AW];
            mwen = (ga != 0);
            if (ga != 0) begin
                mwaddr = ga; mwdata = d[g*DW +: DW]; mknown = 1'b1;
            end else mknown = 1'b0;
        end else mwen = 1'b0;
        last_g = g;
        #1;
        chk("rf_wen", 64'(rf_wen), 64'(mwen));
        if (mknown) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(mwaddr));
            chk("rf_wdata", 64'(rf_wdata), 64'(mwdata));
        end
    endtask

    logic [N*AW-1:0] av;
    logic [N*DW-1:0] dv;
    logic            pv [N];
    logic [AW-1:0]   pa [N];
    logic [DW-1:0]   pd [N];
    int              diffs;

    initial begin
        rst = 1'b1; req_valid = '0; req_waddr = '0; req_wdata = '0;
        // Reset, then single request
        cyc(1'b1, 3'b000, '0, '0);
        cyc(1'b1, 3'b000, '0, '0);
        av = '0; dv = '0; av[0*AW +: AW] = 5'd5; dv[0*DW +: DW] = 32'hDEADBEEF;
        cyc(1'b0, 3'b001, av, dv);
        chk("single_wen", 64'(rf_wen), 64'd1);
        chk("single_data", 64'(rf_wdata), 64'hDEADBEEF);
        cyc(1'b0, 3'b000, '0, '0);

        // Round-robin from ptr=0 with all three valid
        cyc(1'b1, 3'b000, '0, '0);
        av = '0; av[0*AW +: AW] = 5'd1; av[1*AW +: AW] = 5'd2; av[2*AW +: AW] = 5'd3;
        dv = {32'hC3, 32'hC2, 32'hC1};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 3'b111, av, dv);
            chk("rr_addr", 64'(rf_waddr), 64'((i % 3) + 1));
        end
        cyc(1'b0, 3'b000, '0, '0);

        // r0 discard: ptr is 1 now, requester 1 writes r0
        av = '0; dv = '0; dv[1*DW +: DW] = 32'h12345678;
        cyc(1'b0, 3'b010, av, dv);
        chk("r0_wen", 64'(rf_wen), 64'd0);

        // Same-address collision with ptr=2
        av = '0; av[0*AW +: AW] = 5'd7; av[2*AW +: AW] = 5'd7;
        dv = '0; dv[0*DW +: DW] = 32'hA; dv[2*DW +: DW] = 32'hB;
        cyc(1'b0, 3'b101, av, dv);
        chk("coll_first", 64'(last_g), 64'd2);
        cyc(1'b0, 3'b001, av, dv);
        cyc(1'b0, 3'b000, '0, '0);
        cyc(1'b0, 3'b000, '0, '0);
        chk("coll_reg7", 64'(tb_rf[7]), 64'h0000000A);

        // Reset right after a grant drops the pending write
        av = '0; av[0*AW +: AW] = 5'd9; dv = '0; dv[0*DW +: DW] = 32'h99;
        cyc(1'b0, 3'b001, av, dv);
        cyc(1'b1, 3'b000, '0, '0);
        cyc(1'b0, 3'b000, '0, '0);
        chk("rst_reg9", 64'(tb_rf[9]), 64'd0);
        av = '0; av[0*AW +: AW] = 5'd10; av[1*AW +: AW] = 5'd11; av[2*AW +: AW] = 5'd12;
        cyc(1'b0, 3'b111, av, dv);
        chk("rst_ptr0", 64'(last_g), 64'd0);
        cyc(1'b0, 3'b000, '0, '0);

`ifdef RF_WB_FWD_EN
        av = '0; av[0*AW +: AW] = 5'd4; dv = '0; dv[0*DW +: DW] = 32'h55;
        cyc(1'b0, 3'b001, av, dv);
        fwd_raddr1 = 5'd4; rf_rdata1 = 32'h11; fwd_raddr2 = 5'd3; rf_rdata2 = 32'h22;
        #1;
        chk("fwd_hit", 64'(fwd_rdata1), 64'h55);
        chk("fwd_miss2", 64'(fwd_rdata2), 64'h22);
        fwd_raddr1 = 5'd0;
        #1;
        chk("fwd_r0", 64'(fwd_rdata1), 64'h11);
        cyc(1'b0, 3'b000, '0, '0);
`endif

        // Randomized: requesters hold until granted, small address range forces collisions
        for (int i = 0; i < N; i++) begin pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
        for (int c = 0; c < 400; c++) begin
            logic r;
            logic [N-1:0] v;
            for (int i = 0; i < N; i++)
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i] = 1'b1; pa[i] = AW'($urandom_range(0, 7)); pd[i] = $urandom;
                end
            for (int i = 0; i < N; i++) begin
                v[i] = pv[i]; av[i*AW +: AW] = pa[i]; dv[i*DW +: DW] = pd[i];
            end
            r = ($urandom_range(0, 39) == 0);
            cyc(r, v, av, dv);
            if (last_g >= 0) pv[last_g] = 1'b0;
        end
        cyc(1'b0, 3'b000, '0, '0);
        cyc(1'b0, 3'b000, '0, '0);
        diffs = 0;
        for (int i = 0; i < 32; i++) if (tb_rf[i] !== mrf[i]) diffs++;
        chk("rf_contents", 64'(diffs), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
